func_pipe_blk: RTL and testbench
================================

FUNC_PIPE_BLK -- requirements
Module: func_pipe_blk

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width in bits, legal range 8..64.
REQ-002 Parameter PIPE_DEPTH, default 2: number of register stages, legal range 1..8.
REQ-003 Port iClk, input, 1: rising-edge clock.
REQ-004 Port iRsn, input, 1: asynchronous active-low reset.
REQ-005 Port iInValid, input, 1: the operand set on iInA, iInB, iOp and iSatEn is valid.
REQ-006 Port oInReady, output, 1: the block accepts an operand set this cycle.
REQ-007 Port iInA, input, DATA_W: operand A, two's complement.
REQ-008 Port iInB, input, DATA_W: operand B, two's complement.
REQ-009 Port iOp, input, 2: operation select; 00 ADD, 01 SUB (A-B), 10 AND, 11 XOR.
REQ-010 Port iSatEn, input, 1: per-transaction saturation request.
REQ-011 Port iFlush, input, 1: synchronous pipeline flush.
REQ-012 Port oOutValid, output, 1: the result on oOutC and oOutOvf is valid.
REQ-013 Port iOutReady, input, 1: the downstream consumer accepts the result.
REQ-014 Port oOutC, output, DATA_W: result.
REQ-015 Port oOutOvf, output, 1: signed overflow for this result.
REQ-016 Port oResCnt, output, 16: count of completed output handshakes.

Function
REQ-017 An input transfer SHALL occur when iInValid and oInReady are both 1 on a rising edge; an output transfer SHALL occur when oOutValid and iOutReady are both 1.
REQ-018 Each stage SHALL hold a valid bit plus payload; ready[i] = !valid[i] || ready[i+1], and the last stage uses iOutReady.
REQ-019 oInReady SHALL equal ready[0] and SHALL be 0 in any cycle where iFlush is 1.
REQ-020 The result SHALL be computed combinationally at the input and registered into stage 0; every stage beyond that only delays it.
REQ-021 Latency SHALL be PIPE_DEPTH cycles from input transfer to oOutValid while iOutReady is held 1; throughput SHALL be one result per cycle.
REQ-022 While oOutValid=1 and iOutReady=0, oOutC and oOutOvf SHALL stay stable and no stage data SHALL be lost or duplicated.
REQ-023 ADD and SUB SHALL wrap modulo 2^DATA_W.
REQ-024 oOutOvf SHALL be 1 for ADD or SUB when operands of the relevant signs produce a result whose sign differs; it SHALL be 0 for AND and XOR.
REQ-025 The flush SHALL clear all stage valid bits on the next edge. When iFlush and a would-be input transfer coincide, the flush wins and the input is dropped. oResCnt SHALL be unaffected by the flush.
REQ-026 oResCnt SHALL increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.

Reset
REQ-027 On iRsn=0 all valid bits, payloads and oResCnt SHALL clear asynchronously; oOutValid=0, oOutC=0, oOutOvf=0 and oResCnt=0.
REQ-028 Reset deassertion mid-stream SHALL leave the block empty, with oInReady=1 on the first cycle after release.

Configuration
REQ-029 With macro FUNC_PIPE_SAT_EN defined, ADD or SUB with iSatEn=1 and overflow SHALL clamp the result to the signed maximum or minimum of DATA_W while oOutOvf stays 1.
REQ-030 Without FUNC_PIPE_SAT_EN, iSatEn SHALL be ignored, results always wrap, and no saturation logic SHALL be synthesised.

Structure
REQ-031 Package func_pipe_pkg SHALL hold the op encoding enum and the OP_ADD/OP_SUB/OP_AND/OP_XOR constants.
REQ-032 The payload (result plus ovf) SHALL be defined as a typedef parametrised on DATA_W within the package or the module.
REQ-033 One sub-module, func_pipe_stage (a valid/payload register with ready chaining), SHALL be instantiated PIPE_DEPTH times through a generate loop.

Verification
REQ-034 DATA_W=32, PIPE_DEPTH=2, iOutReady=1: ADD 0x00000005+0x00000007 -> oOutC=0x0000000C, oOutOvf=0, exactly 2 cycles after acceptance.
REQ-035 ADD 0x7FFFFFFF+0x00000001 -> oOutC=0x80000000, oOutOvf=1; with FUNC_PIPE_SAT_EN and iSatEn=1 -> oOutC=0x7FFFFFFF, oOutOvf=1.
REQ-036 SUB 0x80000000-0x00000001 -> oOutC=0x7FFFFFFF, oOutOvf=1; XOR 0xFFFF0000^0x0F0F0F0F -> 0xF0F00F0F, oOutOvf=0.
REQ-037 Stream 5 back-to-back ADDs, hold iOutReady=0 for 4 cycles -> oInReady falls after 2 accepts, the output stays stable, and all 5 results arrive in order with oResCnt=5.
REQ-038 Two transactions in flight, assert iFlush for 1 cycle together with iInValid=1 -> no oOutValid follows, the input is not accepted, and oResCnt is unchanged.
REQ-039 Preload oResCnt to 0xFFFF via 65535 transfers, then one more transfer -> oResCnt=0x0000; assert iRsn=0 asynchronously mid-stream -> all outputs are 0 immediately.

Source files
------------

// File: rtl/func_pipe_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the func_pipe arithmetic pipeline: operation encoding.
package func_pipe_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

endpackage

// File: rtl/func_pipe_stage.sv
`timescale 1ns/1ps
// One pipeline slot: valid bit plus payload register. Loads from upstream whenever
// it is empty or the downstream side can take its current contents.
module func_pipe_stage #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         ready_next,
    input  logic         valid_in,
    input  logic [W-1:0] data_in,
    output logic         valid,
    output logic [W-1:0] data
);

    logic load;

    assign load = !valid || ready_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= valid_in;
            // Payload only moves with a valid beat, so a drained output keeps its last value.
            if (valid_in) begin
                data <= data_in;
            end
        end
    end

endmodule

// File: rtl/func_pipe_blk.sv
`timescale 1ns/1ps
// Valid/ready ALU pipe: ADD/SUB/AND/XOR computed at the input, then PIPE_DEPTH stages.
// Saturation on signed ADD/SUB overflow is built only when FUNC_PIPE_SAT_EN is defined.
module func_pipe_blk
    import func_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PIPE_DEPTH = 2
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iInValid,
    output logic              oInReady,
    input  logic [DATA_W-1:0] iInA,
    input  logic [DATA_W-1:0] iInB,
    input  logic [1:0]        iOp,
    input  logic              iSatEn,
    input  logic              iFlush,
    output logic              oOutValid,
    input  logic              iOutReady,
    output logic [DATA_W-1:0] oOutC,
    output logic              oOutOvf,
    output logic [15:0]       oResCnt
);

    typedef struct packed {
        logic              ovf;
        logic [DATA_W-1:0] c;
    } payload_t;

    localparam int PAY_W = $bits(payload_t);
    localparam int MSB   = DATA_W - 1;

    op_e                   op;
    payload_t              calc;
    logic [PIPE_DEPTH-1:0] valid_vec;
    logic [PIPE_DEPTH-1:0] valid_in_vec;
    logic [PIPE_DEPTH-1:0] ready_next;
    payload_t              pay    [PIPE_DEPTH];
    payload_t              pay_in [PIPE_DEPTH];
    logic [15:0]           res_cnt;
    logic                  out_fire;

    assign op = op_e'(iOp);

    always_comb begin
        calc = '0;
        case (op)
            OP_ADD: begin
                calc.c   = iInA + iInB;
                calc.ovf = (iInA[MSB] == iInB[MSB]) && (calc.c[MSB] != iInA[MSB]);
            end
            OP_SUB: begin
                calc.c   = iInA - iInB;
                calc.ovf = (iInA[MSB] != iInB[MSB]) && (calc.c[MSB] != iInA[MSB]);
            end
            OP_AND:  calc.c = iInA & iInB;
            OP_XOR:  calc.c = iInA ^ iInB;
            default: calc = '0;
        endcase
`ifdef FUNC_PIPE_SAT_EN
        // On overflow the true result lies on the side of operand A's sign, for ADD and SUB alike.
        if (iSatEn && calc.ovf) begin
            calc.c = iInA[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end
`endif
    end

`ifndef FUNC_PIPE_SAT_EN
    logic unused_sat_en;
    assign unused_sat_en = iSatEn;
`endif

    assign valid_in_vec[0] = iInValid;
    assign pay_in[0]       = calc;

    // Downstream readiness is expanded from the valid bits directly, so the chain has no combinational loop.
    genvar i;
    generate
        for (i = 0; i < PIPE_DEPTH; i++) begin : g_stage
            if (i > 0) begin : g_link
                assign valid_in_vec[i] = valid_vec[i-1];
                assign pay_in[i]       = pay[i-1];
            end
            if (i == PIPE_DEPTH - 1) begin : g_last
                assign ready_next[i] = iOutReady;
            end else begin : g_mid
                assign ready_next[i] = iOutReady || !(&valid_vec[PIPE_DEPTH-1:i+1]);
            end
            func_pipe_stage #(
                .W (PAY_W)
            ) u_stage (
                .clk        (iClk),
                .rst_n      (iRsn),
                .flush      (iFlush),
                .ready_next (ready_next[i]),
                .valid_in   (valid_in_vec[i]),
                .data_in    (pay_in[i]),
                .valid      (valid_vec[i]),
                .data       (pay[i])
            );
        end
    endgenerate

    assign oInReady  = (!valid_vec[0] || ready_next[0]) && !iFlush;
    assign oOutValid = valid_vec[PIPE_DEPTH-1];
    assign oOutC     = pay[PIPE_DEPTH-1].c;
    assign oOutOvf   = pay[PIPE_DEPTH-1].ovf;
    assign out_fire  = valid_vec[PIPE_DEPTH-1] && iOutReady;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            res_cnt <= '0;
        end else if (out_fire) begin
            res_cnt <= res_cnt + 16'd1;
        end
    end

    assign oResCnt = res_cnt;

endmodule

// File: tb/tb_func_pipe_blk.sv
`timescale 1ns/1ps
// Directed plus randomized bench for func_pipe_blk with an in-order result queue model.
module tb_func_pipe_blk;

    localparam int DW = 32;
    localparam int PD = 2;

    typedef struct {
        logic [DW-1:0] c;
        logic          ovf;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          sat_en    = 1'b0;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] a         = '0;
    logic [DW-1:0] b         = '0;
    logic [1:0]    op        = 2'b00;
    logic          in_ready;
    logic          out_valid;
    logic          ovf;
    logic [DW-1:0] c;
    logic [15:0]   res_cnt;

    exp_t        exp_q[$];
    int unsigned cnt_model = 0;
    int          n_assert  = 0;
    int          n_fail    = 0;
    bit          last_acc;
    bit          last_out;

    func_pipe_blk #(
        .DATA_W     (DW),
        .PIPE_DEPTH (PD)
    ) dut (
        .iClk      (clk),
        .iRsn      (rst_n),
        .iInValid  (in_valid),
        .oInReady  (in_ready),
        .iInA      (a),
        .iInB      (b),
        .iOp       (op),
        .iSatEn    (sat_en),
        .iFlush    (flush),
        .oOutValid (out_valid),
        .iOutReady (out_ready),
        .oOutC     (c),
        .oOutOvf   (ovf),
        .oResCnt   (res_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact signed arithmetic in 64 bits, overflow when outside the DW-bit signed range.
    function automatic exp_t ref_calc(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                      input logic [1:0] o, input logic s);
        exp_t   e;
        longint sx, sy, r;
        longint maxv, minv;
        bit     sat_on;
        maxv   = (longint'(1) <<< (DW - 1)) - 1;
        minv   = -(longint'(1) <<< (DW - 1));
        sx     = longint'($signed(x));
        sy     = longint'($signed(y));
        sat_on = 1'b0;
`ifdef FUNC_PIPE_SAT_EN
        sat_on = s;
`else
        if (s) sat_on = 1'b0;
`endif
        e.ovf = 1'b0;
        r     = 0;
        case (o)
            2'd0:    r = sx + sy;
            2'd1:    r = sx - sy;
            default: r = 0;
        endcase
        if (o == 2'd0 || o == 2'd1) begin
            e.ovf = (r > maxv) || (r < minv);
            e.c   = r[DW-1:0];
            if (sat_on && e.ovf) e.c = (r > maxv) ? maxv[DW-1:0] : minv[DW-1:0];
        end else if (o == 2'd2) begin
            e.c = x & y;
        end else begin
            e.c = x ^ y;
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: settle, score the handshakes seen this cycle, advance, check the counter.
    task automatic tick();
        exp_t e;
        #1;
        last_acc = in_valid && in_ready;
        last_out = out_valid && out_ready;
        if (flush) chk("in_ready_under_flush", 64'(in_ready), 64'(0));
        if (out_valid) begin
            chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                chk("out_c", 64'(c), 64'(exp_q[0].c));
                chk("out_ovf", 64'(ovf), 64'(exp_q[0].ovf));
            end
        end
        if (last_out) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            cnt_model++;
        end
        if (flush) exp_q.delete();
        if (last_acc && !flush) exp_q.push_back(ref_calc(a, b, op, sat_en));
        @(posedge clk);
        #1;
        chk("res_cnt", 64'(res_cnt), 64'(cnt_model & 32'h0000_FFFF));
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        sat_en    = 1'b0;
        rst_n     = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_c", 64'(c), 64'(0));
        chk("rst_out_ovf", 64'(ovf), 64'(0));
        chk("rst_res_cnt", 64'(res_cnt), 64'(0));
        exp_q.delete();
        cnt_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready_first_cycle", 64'(in_ready), 64'(1));
    endtask

    task automatic run_one(input string tag, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                           input logic [1:0] ov, input logic sv,
                           input logic [DW-1:0] exp_c, input logic exp_ovf);
        int lat;
        out_ready = 1'b1;
        a         = av;
        b         = bv;
        op        = ov;
        sat_en    = sv;
        in_valid  = 1'b1;
        tick();
        chk({tag, "_accept"}, 64'(last_acc), 64'(1));
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(PD));
        chk({tag, "_c"}, 64'(c), 64'(exp_c));
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
        tick();
        sat_en = 1'b0;
    endtask

    initial begin
        int idx;
        int guard;
        logic [DW-1:0] sat_add_exp;
        logic [DW-1:0] sat_sub_exp;

        do_reset();

        // Directed operations and boundaries.
`ifdef FUNC_PIPE_SAT_EN
        sat_add_exp = 32'h7FFF_FFFF;
        sat_sub_exp = 32'h8000_0000;
`else
        sat_add_exp = 32'h8000_0000;
        sat_sub_exp = 32'h7FFF_FFFF;
`endif
        run_one("add_small",   32'h0000_0005, 32'h0000_0007, 2'b00, 1'b0, 32'h0000_000C, 1'b0);
        run_one("add_posovf",  32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h8000_0000, 1'b1);
        run_one("add_sat",     32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b1, sat_add_exp,   1'b1);
        run_one("sub_negovf",  32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, 32'h7FFF_FFFF, 1'b1);
        run_one("sub_sat",     32'h8000_0000, 32'h0000_0001, 2'b01, 1'b1, sat_sub_exp,   1'b1);
        run_one("add_negovf",  32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h7FFF_FFFF, 1'b1);
        run_one("xor",         32'hFFFF_0000, 32'h0F0F_0F0F, 2'b11, 1'b0, 32'hF0F0_0F0F, 1'b0);
        run_one("and_sat_ign", 32'hFFFF_0000, 32'h0F0F_0F0F, 2'b10, 1'b1, 32'h0F0F_0000, 1'b0);
        run_one("sub_neg",     32'h0000_0003, 32'h0000_0005, 2'b01, 1'b0, 32'hFFFF_FFFE, 1'b0);

        // Backpressure: five ADDs, output stalled for four cycles.
        do_reset();
        out_ready = 1'b0;
        op        = 2'b00;
        in_valid  = 1'b1;
        a = 32'd100; b = 32'd1;
        tick();
        chk("stall_accept0", 64'(last_acc), 64'(1));
        a = 32'd200; b = 32'd2;
        tick();
        chk("stall_accept1", 64'(last_acc), 64'(1));
        a = 32'd300; b = 32'd3;
        #1;
        chk("stall_in_ready_low", 64'(in_ready), 64'(0));
        repeat (4) begin
            tick();
            chk("stall_no_accept", 64'(last_acc), 64'(0));
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_out_c", 64'(c), 64'(32'd101));
        end
        out_ready = 1'b1;
        idx   = 2;
        guard = 0;
        while (idx < 5 && guard < 40) begin
            a = DW'(100 * (idx + 1));
            b = DW'(idx + 1);
            tick();
            if (last_acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        chk("stall_all_sent", 64'(idx), 64'(5));
        for (int k = 0; k < 20 && (exp_q.size() != 0 || out_valid); k++) tick();
        chk("stall_drained", 64'(exp_q.size()), 64'(0));
        chk("stall_res_cnt", 64'(res_cnt), 64'(5));

        // Flush with two in flight and a coincident input.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 2'b00;
        a = 32'd1; b = 32'd2;
        tick();
        a = 32'd3; b = 32'd4;
        tick();
        flush = 1'b1;
        a = 32'd5; b = 32'd6;
        tick();
        chk("flush_input_dropped", 64'(last_acc), 64'(0));
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("flush_no_out_valid", 64'(out_valid), 64'(0));
        end
        chk("flush_res_cnt", 64'(res_cnt), 64'(0));

        // Randomized traffic with backpressure and occasional flushes.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            a         = pick();
            b         = pick();
            op        = 2'($urandom_range(0, 3));
            sat_en    = 1'($urandom_range(0, 1));
        tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (exp_q.size() != 0 || out_valid); k++) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'(0));

        // Counter wrap, then asynchronous reset with the pipe full.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        guard     = 0;
        while (cnt_model < 32'd65535 && guard < 70000) begin
            a  = $urandom();
            b  = $urandom();
            op = 2'($urandom_range(0, 3));
            tick();
            guard++;
        end
        chk("cnt_at_ffff", 64'(res_cnt), 64'(16'hFFFF));
        guard = 0;
        while (cnt_model < 32'd65536 && guard < 10) begin
            tick();
            guard++;
        end
        chk("cnt_wrapped", 64'(res_cnt), 64'(0));
        chk("wrap_pipe_busy", 64'(out_valid), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'(0));
        chk("async_rst_out_c", 64'(c), 64'(0));
        chk("async_rst_out_ovf", 64'(ovf), 64'(0));
        chk("async_rst_res_cnt", 64'(res_cnt), 64'(0));
        do_reset();
        tick();
        chk("post_rst_empty", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
